adc_spi_responder: RTL

ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

---
 rtl/adc_pkg.sv | 25 ++
 rtl/spi_edge_sync.sv | 32 +++
 rtl/adc_spi_responder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared constants and types for the ADC SPI responder.
package adc_pkg;

    localparam int CMD_BITS = 24;
    localparam int CNV_BITS = 32;
    localparam int CNT_BITS = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FINISH = 2'd2
    } spi_state_t;

    // One bit set at the LSB position of every lane slice of the sample word.
    // Clearing these after a left shift keeps each lane shifting on its own.
    function automatic logic [CNV_BITS-1:0] lane_lsb_mask(input int num_sdo);
        logic [CNV_BITS-1:0] m;
        m = '0;
        for (int i = 0; i < num_sdo; i++) begin
            m[i*(CNV_BITS/num_sdo)] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes one asynchronous SPI wire into aclk and flags its edges.
module spi_edge_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Shift the raw input through the chain and keep last synchronized value.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI target that streams conversion samples out on NUM_SDO lanes and
// captures 24-bit register commands into an AXI-Stream master.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for csn falling edge, accepting new samples
//   ST_ACTIVE | frame open: shift sample out, capture sdi, count sclk rises
//   ST_FINISH | frame closed: classify by rise count, emit command/error
module adc_spi_responder
    import adc_pkg::*;
#(
    parameter int NUM_SDO     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                spi_csn,
    input  logic                spi_sclk,
    input  logic                spi_sdi,
    output logic [NUM_SDO-1:0]  spi_sdo,
    input  logic [CNV_BITS-1:0] s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [CMD_BITS-1:0] m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                frame_err,
    output logic                cmd_overflow
);

    localparam int                  W         = CNV_BITS / NUM_SDO;
    localparam logic [CNV_BITS-1:0] LANE_LSB  = lane_lsb_mask(NUM_SDO);
    localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;
    localparam logic [CNT_BITS-1:0] CNT_CMD   = CNT_BITS'(CMD_BITS);
    localparam logic [CNT_BITS-1:0] CNT_CNV   = CNT_BITS'(W);
    localparam logic [2:0]          FILL_DONE = 3'(SYNC_STAGES + 1);

    logic w_csn_level, w_csn_rise, w_csn_fall;
    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_sdi_level, w_sdi_rise, w_sdi_fall;
    logic w_unused_edges;

    spi_state_t          r_state;
    logic [CNV_BITS-1:0] r_sample;
    logic [CNV_BITS-1:0] r_shift;
    logic [CMD_BITS-1:0] r_cmd;
    logic [CNT_BITS-1:0] r_cnt;
    logic [CMD_BITS-1:0] r_m_data;
    logic                r_m_valid;
    logic                r_s_ready;
    logic                r_frame_err;
    logic                r_cmd_ovf;
    logic [2:0]          r_fill;
    logic                r_armed;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_async (spi_csn),
        .o_level (w_csn_level),
        .o_rise  (w_csn_rise),
        .o_fall  (w_csn_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_async (spi_sclk),
        .o_level (w_sclk_level),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_async (spi_sdi),
        .o_level (w_sdi_level),
        .o_rise  (w_sdi_rise),
        .o_fall  (w_sdi_fall)
    );

    assign w_unused_edges = w_sclk_level ^ w_sdi_rise ^ w_sdi_fall;

    // Frame FSM with shift/capture datapath and registered stream/pulse outputs.
    // r_armed blocks the synthetic csn fall seen when the chain refills after
    // reset with csn already low; a frame needs csn seen high first.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_sample    <= '0;
            r_shift     <= '0;
            r_cmd       <= '0;
            r_cnt       <= '0;
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
            r_s_ready   <= 1'b1;
            r_frame_err <= 1'b0;
            r_cmd_ovf   <= 1'b0;
            r_fill      <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_cmd_ovf   <= 1'b0;

            if (r_fill != FILL_DONE) begin
                r_fill <= r_fill + 1'b1;
            end else if (w_csn_level) begin
                r_armed <= 1'b1;
            end

            if (r_m_valid && m_axis_tready) begin
                r_m_valid <= 1'b0;
            end

            if (s_axis_tvalid && r_s_ready) begin
                r_sample <= s_axis_tdata;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_armed && w_csn_fall) begin
                        r_state   <= ST_ACTIVE;
                        r_s_ready <= 1'b0;
                        r_cnt     <= '0;
                        r_shift   <= (s_axis_tvalid && r_s_ready) ? s_axis_tdata : r_sample;
                    end
                end
                ST_ACTIVE: begin
                    if (w_sclk_fall) begin
                        r_shift <= (r_shift << 1) & ~LANE_LSB;
                    end
                    if (w_sclk_rise) begin
                        r_cmd <= {r_cmd[CMD_BITS-2:0], w_sdi_level};
                        if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    if (w_csn_rise) begin
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    r_state   <= ST_IDLE;
                    r_s_ready <= 1'b1;
                    if (r_cnt == CNT_CMD) begin
                        if (r_m_valid) begin
                            r_cmd_ovf <= 1'b1;
                        end else begin
                            r_m_valid <= 1'b1;
                            r_m_data  <= r_cmd;
                        end
                    end else if (r_cnt != CNT_CNV) begin
                        r_frame_err <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_s_ready <= 1'b1;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_SDO; g++) begin : g_lane
        assign spi_sdo[g] = (r_state == ST_ACTIVE) && r_shift[(NUM_SDO-g)*W-1];
    end

    assign s_axis_tready = r_s_ready;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tvalid = r_m_valid;
    assign frame_err     = r_frame_err;
    assign cmd_overflow  = r_cmd_ovf;

endmodule
